dm_access_unit: RTL

//  Multi-cycle load/store engine between the CPU datapath and the data-memory bus.

---
 rtl/dm_access_unit_pkg.sv | 50 +++++
 rtl/dm_lane_ext.sv | 34 +++
 rtl/dm_access_unit.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/dm_access_unit_pkg.sv
// Shared access-size encodings and the per-size address/lane helpers.
package dm_access_unit_pkg;

    localparam logic [2:0] DM_WORD   = 3'd0;
    localparam logic [2:0] DM_HALF   = 3'd1;
    localparam logic [2:0] DM_HALF_U = 3'd2;
    localparam logic [2:0] DM_BYTE   = 3'd3;
    localparam logic [2:0] DM_BYTE_U = 3'd4;

    typedef enum logic [1:0] {
        SZ_WORD,
        SZ_HALF,
        SZ_BYTE
    } dm_size_e;

    // Any encoding outside the known set is handled as a full word.
    function automatic dm_size_e dm_size(input logic [2:0] dm_type);
        case (dm_type)
            DM_HALF, DM_HALF_U: dm_size = SZ_HALF;
            DM_BYTE, DM_BYTE_U: dm_size = SZ_BYTE;
            default:            dm_size = SZ_WORD;
        endcase
    endfunction

    function automatic logic dm_aligned(input logic [2:0] dm_type, input logic [1:0] addr_lo);
        case (dm_size(dm_type))
            SZ_HALF: dm_aligned = (addr_lo[0] == 1'b0);
            SZ_BYTE: dm_aligned = 1'b1;
            default: dm_aligned = (addr_lo == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] dm_byte_en(input logic [2:0] dm_type, input logic [1:0] addr_lo);
        case (dm_size(dm_type))
            SZ_HALF: dm_byte_en = 4'b0011 << addr_lo;
            SZ_BYTE: dm_byte_en = 4'b0001 << addr_lo;
            default: dm_byte_en = 4'b1111;
        endcase
    endfunction

    // Store data is replicated so the selected lane carries it whatever the offset.
    function automatic logic [31:0] dm_store_data(input logic [2:0] dm_type, input logic [31:0] wd);
        case (dm_size(dm_type))
            SZ_HALF: dm_store_data = {2{wd[15:0]}};
            SZ_BYTE: dm_store_data = {4{wd[7:0]}};
            default: dm_store_data = wd;
        endcase
    endfunction

endpackage

// File: rtl/dm_lane_ext.sv
// Picks the addressed byte/half out of a bus word and sign/zero-extends it.
module dm_lane_ext
    import dm_access_unit_pkg::*;
(
    input  logic [31:0] bus_rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  dm_type,
    output logic [31:0] data_ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select followed by extension chosen by the access type.
    always_comb begin
        byte_sel = bus_rdata[7:0];
        case (addr_lo)
            2'd1:    byte_sel = bus_rdata[15:8];
            2'd2:    byte_sel = bus_rdata[23:16];
            2'd3:    byte_sel = bus_rdata[31:24];
            default: byte_sel = bus_rdata[7:0];
        endcase
        half_sel = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];

        case (dm_type)
            DM_HALF:   data_ext = {{16{half_sel[15]}}, half_sel};
            DM_HALF_U: data_ext = {16'h0000, half_sel};
            DM_BYTE:   data_ext = {{24{byte_sel[7]}}, byte_sel};
            DM_BYTE_U: data_ext = {24'h000000, byte_sel};
            default:   data_ext = bus_rdata;
        endcase
    end

endmodule

// File: rtl/dm_access_unit.sv
// Multi-cycle load/store engine: CPU MemRead/MemWrite in, req/ack data bus out.
//
//   state | meaning
//   IDLE  | waiting for an op; misaligned ops fault here without touching the bus
//   BUSY  | bus_req held with stable address/enables until ack or timeout
//   DONE  | one cycle with Stall low so the CPU retires the op; no new op accepted
module dm_access_unit
    import dm_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  DMType,
    input  logic [31:0] Addr,
    input  logic [31:0] WD,
    output logic        Stall,
    output logic [31:0] DataOut,
    output logic        Fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        fault_q, fault_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] data_out_q, data_out_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  type_q, type_d;

    logic        op;
    logic        aligned;
    logic [31:0] load_ext;

    assign op      = MemRead | MemWrite;
    assign aligned = dm_aligned(DMType, Addr[1:0]);

    // Offset and type are captured at issue so extension does not depend on
    // the CPU keeping Addr/DMType stable through the whole access.
    dm_lane_ext u_lane_ext (
        .bus_rdata (bus_rdata),
        .addr_lo   (off_q),
        .dm_type   (type_q),
        .data_ext  (load_ext)
    );

    // Next-state, bus register updates and combinational Stall.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fault_d     = 1'b0;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        data_out_d  = data_out_q;
        off_d       = off_q;
        type_d      = type_q;
        Stall       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (op) begin
                    if (aligned) begin
                        Stall       = 1'b1;
                        state_d     = ST_BUSY;
                        cnt_d       = 8'd0;
                        bus_req_d   = 1'b1;
                        bus_we_d    = MemWrite;
                        bus_addr_d  = {Addr[31:2], 2'b00};
                        bus_be_d    = dm_byte_en(DMType, Addr[1:0]);
                        bus_wdata_d = dm_store_data(DMType, WD);
                        off_d       = Addr[1:0];
                        type_d      = DMType;
                    end else begin
                        fault_d = 1'b1;
                    end
                end
            end
            ST_BUSY: begin
                Stall = 1'b1;
                if (bus_ack) begin
                    state_d   = ST_DONE;
                    bus_req_d = 1'b0;
                    if (!bus_we_q) begin
                        data_out_d = load_ext;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = ST_IDLE;
                    bus_req_d = 1'b0;
                    fault_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight access.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            fault_q     <= 1'b0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'h0;
            bus_be_q    <= 4'h0;
            bus_wdata_q <= 32'h0;
            data_out_q  <= 32'h0;
            off_q       <= 2'b00;
            type_q      <= DM_WORD;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fault_q     <= fault_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            data_out_q  <= data_out_d;
            off_q       <= off_d;
            type_q      <= type_d;
        end
    end

    assign Fault     = fault_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
    assign DataOut   = data_out_q;

endmodule
